pid_axis_engine: RTL and testbench

Time-multiplexed, parametrised PID term engine for the flight controller. It computes the P, I and D terms for NUM_AXES attitude axes (pitch/roll/yaw by default) with a single shared datapath, sequenced one axis per clock after each valid inertial reading. It sits between the inertial interface / cmd_cfg and the motor mixing sums, and adds a saturating, anti-windup integrator that the previous per-axis logic lacked.

---
 rtl/pid_axis_engine.sv | 200 ++++++++++++++++++++
 tb/tb_pid_axis_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_axis_engine.sv
// Time-multiplexed PID term engine: one shared datapath walks the axes one per clock
// after each accepted vld, with a saturating anti-windup integrator and a per-axis D delay queue.
module pid_axis_engine #(
    parameter int NUM_AXES = 3,
    parameter int ERR_W    = 10,
    parameter int D_DEPTH  = 14,
    parameter int D_COEFF  = 7,
    parameter int I_SHIFT  = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vld,
    input  logic [NUM_AXES*16-1:0]        actual,
    input  logic [NUM_AXES*16-1:0]        desired,
    input  logic                          clr_integ,
    output logic                          busy,
    output logic                          done,
    output logic                          ovr,
    output logic [NUM_AXES*ERR_W-1:0]     pterm,
    output logic [NUM_AXES*ERR_W-1:0]     iterm,
    output logic [NUM_AXES*(ERR_W+2)-1:0] dterm
);
    localparam int ACC_W = ERR_W + I_SHIFT;
    localparam int DT_W  = ERR_W + 2;
    localparam int DIF_W = ERR_W + 1;
    localparam int CH_W  = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam int PTR_W = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_AXES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(D_DEPTH - 1);
    localparam logic signed [ERR_W-1:0] E_MAX = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic signed [ERR_W-1:0] E_MIN = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic signed [DIF_W-1:0] D_HI  = DIF_W'(32'sd31);
    localparam logic signed [DIF_W-1:0] D_LO  = DIF_W'(-32'sd32);
    localparam logic signed [ACC_W:0]   A_HI  = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   A_LO  = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [DT_W-1:0]  COEFF = DT_W'(D_COEFF);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [16:0] v);
        if (v > 17'(E_MAX))      sat_err = E_MAX;
        else if (v < 17'(E_MIN)) sat_err = E_MIN;
        else                     sat_err = v[ERR_W-1:0];
    endfunction

    function automatic logic signed [5:0] sat_diff(input logic signed [DIF_W-1:0] v);
        if (v > D_HI)      sat_diff = 6'sd31;
        else if (v < D_LO) sat_diff = -6'sd32;
        else               sat_diff = v[5:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        if (v > A_HI)      sat_acc = A_HI[ACC_W-1:0];
        else if (v < A_LO) sat_acc = A_LO[ACC_W-1:0];
        else               sat_acc = v[ACC_W-1:0];
    endfunction

    state_t                     state_q, state_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [NUM_AXES*16-1:0]     act_q, act_d, des_q, des_d;
    logic signed [ERR_W-1:0]    dbuf_q [NUM_AXES][D_DEPTH];
    logic signed [ERR_W-1:0]    dbuf_d [NUM_AXES][D_DEPTH];
    logic signed [ACC_W-1:0]    acc_q [NUM_AXES];
    logic signed [ACC_W-1:0]    acc_d [NUM_AXES];
    logic [NUM_AXES*ERR_W-1:0]  pterm_q, pterm_d;
    logic [NUM_AXES*DT_W-1:0]   dterm_q, dterm_d;
    logic                       busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;

    logic signed [15:0]         cur_act_s, cur_des_s;
    logic signed [16:0]         err_wide_s;
    logic signed [ERR_W-1:0]    err_sat_s, oldest_s, psum_s;
    logic signed [DIF_W-1:0]    diff_s;
    logic signed [5:0]          diff_sat_s;
    logic signed [DT_W-1:0]     dprod_s;
    logic signed [ACC_W:0]      asum_s;
    logic signed [ACC_W-1:0]    acc_upd_s;
    int                         ch_i;

    // Shared datapath for the selected axis, FSM sequencing and next-state of all storage.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        act_d   = act_q;
        des_d   = des_q;
        dbuf_d  = dbuf_q;
        acc_d   = acc_q;
        pterm_d = pterm_q;
        dterm_d = dterm_q;
        ovr_d   = 1'b0;
        ch_i    = int'(ch_q);

        cur_act_s  = act_q[ch_i*16 +: 16];
        cur_des_s  = des_q[ch_i*16 +: 16];
        err_wide_s = {cur_act_s[15], cur_act_s} - {cur_des_s[15], cur_des_s};
        err_sat_s  = sat_err(err_wide_s);
        oldest_s   = dbuf_q[ch_q][ptr_q];
        diff_s     = {err_sat_s[ERR_W-1], err_sat_s} - {oldest_s[ERR_W-1], oldest_s};
        diff_sat_s = sat_diff(diff_s);
        dprod_s    = DT_W'(diff_sat_s) * COEFF;
        psum_s     = (err_sat_s >>> 1) + (err_sat_s >>> 3);
        asum_s     = {acc_q[ch_q][ACC_W-1], acc_q[ch_q]} + (ACC_W+1)'(err_sat_s);
        // A pinned error means the sensor range is exceeded; integrating it only winds up.
        if ((err_sat_s == E_MAX) || (err_sat_s == E_MIN)) begin
            acc_upd_s = acc_q[ch_q];
        end else begin
            acc_upd_s = sat_acc(asum_s);
        end

        case (state_q)
            S_IDLE: begin
                if (vld) begin
                    act_d   = actual;
                    des_d   = desired;
                    ch_d    = CH_W'(0);
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                ovr_d                            = vld;
                pterm_d[ch_i*ERR_W +: ERR_W]     = psum_s;
                dterm_d[ch_i*DT_W +: DT_W]       = dprod_s;
                dbuf_d[ch_q][ptr_q]              = err_sat_s;
                acc_d[ch_q]                      = acc_upd_s;
                if (ch_q == CH_LAST) begin
                    ch_d    = CH_W'(0);
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                end
            end
            S_DONE: begin
                ovr_d   = vld;
                state_d = S_IDLE;
                ptr_d   = (ptr_q == PTR_LAST) ? PTR_W'(0) : ptr_q + PTR_W'(1);
            end
            default: begin
                state_d = S_IDLE;
                ch_d    = CH_W'(0);
            end
        endcase

        if (clr_integ) begin
            for (int k = 0; k < NUM_AXES; k++) acc_d[k] = '0;
        end else begin
            acc_d = acc_d;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, snapshot, queue, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            ptr_q   <= '0;
            act_q   <= '0;
            des_q   <= '0;
            for (int k = 0; k < NUM_AXES; k++) begin
                acc_q[k] <= '0;
                for (int j = 0; j < D_DEPTH; j++) dbuf_q[k][j] <= '0;
            end
            pterm_q <= '0;
            dterm_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            act_q   <= act_d;
            des_q   <= des_d;
            acc_q   <= acc_d;
            dbuf_q  <= dbuf_d;
            pterm_q <= pterm_d;
            dterm_q <= dterm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign ovr   = ovr_q;
    assign pterm = pterm_q;
    assign dterm = dterm_q;

    for (genvar k = 0; k < NUM_AXES; k++) begin : g_iterm
        logic signed [ACC_W-1:0] ishift_s;
        assign ishift_s = acc_q[k] >>> I_SHIFT;
        assign iterm[k*ERR_W +: ERR_W] = ishift_s[ERR_W-1:0];
    end
endmodule

// File: tb/tb_pid_axis_engine.sv
// Self-checking bench for pid_axis_engine: directed vector table, hand-written corner
// sequences and randomized passes compared against an arithmetic reference model.
module tb_pid_axis_engine;
    localparam int NA = 3;
    localparam int EW = 10;
    localparam int DW = EW + 2;
    localparam int DD = 14;
    localparam int BW = NA * 16;

    logic          clk = 1'b0;
    logic          rst_n, vld, clr_integ, busy, done, ovr;
    logic [BW-1:0] actual, desired;
    logic [NA*EW-1:0] pterm, iterm;
    logic [NA*DW-1:0] dterm;

    int checks = 0;
    int failures = 0;
    int m_buf [NA][DD];
    int m_acc [NA];
    int m_ptr;
    int e_p [NA];
    int e_d [NA];

    typedef struct {
        logic [15:0] a0;
        logic [15:0] d0;
        int          ep;
        int          ei;
        int          ed;
    } vec_t;

    always #5 clk = ~clk;

    pid_axis_engine #(.NUM_AXES(NA), .ERR_W(EW), .D_DEPTH(DD), .D_COEFF(7), .I_SHIFT(6)) dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .actual(actual), .desired(desired),
        .clr_integ(clr_integ), .busy(busy), .done(done), .ovr(ovr),
        .pterm(pterm), .iterm(iterm), .dterm(dterm)
    );

    function automatic int clampi(int v, int lo, int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int get_p(int k);
        logic signed [EW-1:0] v;
        v = pterm[k*EW +: EW];
        return int'(v);
    endfunction

    function automatic int get_i(int k);
        logic signed [EW-1:0] v;
        v = iterm[k*EW +: EW];
        return int'(v);
    endfunction

    function automatic int get_d(int k);
        logic signed [DW-1:0] v;
        v = dterm[k*DW +: DW];
        return int'(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int k = 0; k < NA; k++) begin
            m_acc[k] = 0;
            e_p[k]   = 0;
            e_d[k]   = 0;
            for (int j = 0; j < DD; j++) m_buf[k][j] = 0;
        end
    endtask

    // One complete pass in plain arithmetic; clr0 models a clear landing on the axis-0 update.
    task automatic model_pass(input logic [BW-1:0] a, input logic [BW-1:0] d, input bit clr0);
        for (int k = 0; k < NA; k++) begin
            logic signed [15:0] av, dv;
            int es;
            av = a[k*16 +: 16];
            dv = d[k*16 +: 16];
            es = clampi(int'(av) - int'(dv), -512, 511);
            e_p[k] = (es >>> 1) + (es >>> 3);
            e_d[k] = clampi(es - m_buf[k][m_ptr], -32, 31) * 7;
            m_buf[k][m_ptr] = es;
            if (clr0 && k == 0) begin
                for (int j = 0; j < NA; j++) m_acc[j] = 0;
            end else if (es != 511 && es != -512) begin
                m_acc[k] = clampi(m_acc[k] + es, -32768, 32767);
            end
        end
        m_ptr = (m_ptr + 1) % DD;
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < NA; k++) begin
            check($sformatf("%s_pterm%0d", tag, k), get_p(k), e_p[k]);
            check($sformatf("%s_iterm%0d", tag, k), get_i(k), m_acc[k] >>> 6);
            check($sformatf("%s_dterm%0d", tag, k), get_d(k), e_d[k]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vld = 1'b0; clr_integ = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_pass(input logic [BW-1:0] a, input logic [BW-1:0] d, input bit clr0);
        int lat;
        @(negedge clk);
        actual = a; desired = d; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        if (clr0) clr_integ = 1'b1;
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            clr_integ = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("done_latency", lat, NA);
        model_pass(a, d, clr0);
        check_outputs("pass");
        @(negedge clk);
        check("busy_released", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
    endtask

    function automatic logic [BW-1:0] ax0(input int v);
        logic [BW-1:0] r;
        r = '0;
        r[15:0] = 16'(v);
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [3];
        int   dc, prev, cur;
        logic [BW-1:0] ra, rd;

        rst_n = 1'b0; vld = 1'b0; clr_integ = 1'b0;
        actual = '0; desired = '0;
        model_reset();
        #12;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_ovr", int'(ovr), 0);
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{16'd100,  16'd0,    62, 1, 217};
        tbl[1] = '{16'h7FFF, 16'h8000, 318, 1, 217};
        tbl[2] = '{16'hFC18, 16'd0,  -320, 1, -224};
        for (int i = 0; i < 3; i++) begin
            run_pass(ax0(int'(tbl[i].a0)), ax0(int'(tbl[i].d0)), 1'b0);
            check($sformatf("tbl%0d_pterm0", i), get_p(0), tbl[i].ep);
            check($sformatf("tbl%0d_iterm0", i), get_i(0), tbl[i].ei);
            check($sformatf("tbl%0d_dterm0", i), get_d(0), tbl[i].ed);
            check($sformatf("tbl%0d_pterm1", i), get_p(1), 0);
            check($sformatf("tbl%0d_dterm2", i), get_d(2), 0);
        end

        // Reset while the pass is mid-CALC: everything back to zero, no done.
        @(negedge clk);
        actual = ax0(300); desired = '0; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("midrst_no_done", dc, 0);

        // Constant error through the D queue, across the pointer wrap.
        for (int p = 1; p <= 30; p++) begin
            run_pass(ax0(20), '0, 1'b0);
            check($sformatf("dq_pass%0d_dterm0", p), get_d(0), (p <= DD) ? 140 : 0);
        end

        // Second vld during the pass is dropped, flagged once and does not disturb the snapshot.
        @(negedge clk);
        actual = ax0(77); desired = ax0(-5); vld = 1'b1;
        @(negedge clk);
        actual = ax0(-400);
        @(negedge clk);
        check("ovr_pulse", int'(ovr), 1);
        vld = 1'b0;
        @(negedge clk);
        check("ovr_cleared", int'(ovr), 0);
        dc = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("ovr_single_done", dc, 1);
        model_pass(ax0(77), ax0(-5), 1'b0);
        check_outputs("ovr");

        // Clear landing on the axis-0 update beats the update and empties axes 1-2 too.
        run_pass({16'd40, 16'd40, 16'd40}, '0, 1'b0);
        run_pass(ax0(50), '0, 1'b1);
        check("clr_iterm0", get_i(0), 0);
        check("clr_iterm1", get_i(1), 0);
        check("clr_iterm2", get_i(2), 0);

        // Windup against the accumulator ceiling, then unwinding.
        do_reset();
        for (int p = 0; p < 200; p++) run_pass(ax0(300), '0, 1'b0);
        check("windup_iterm0_max", get_i(0), 511);
        prev = get_i(0);
        for (int p = 0; p < 10; p++) begin
            run_pass(ax0(-300), '0, 1'b0);
            cur = get_i(0);
            check($sformatf("unwind%0d_decreasing", p), (cur < prev) ? 1 : 0, 1);
            prev = cur;
        end

        // Randomized passes with occasional clears.
        do_reset();
        for (int p = 0; p < 150; p++) begin
            for (int k = 0; k < NA; k++) begin
                int base;
                if ($urandom_range(0, 3) == 0) begin
                    ra[k*16 +: 16] = 16'($urandom);
                    rd[k*16 +: 16] = 16'($urandom);
                end else begin
                    base = int'($urandom_range(0, 800)) - 400;
                    rd[k*16 +: 16] = 16'(base);
                    ra[k*16 +: 16] = 16'(base + int'($urandom_range(0, 1400)) - 700);
                end
            end
            run_pass(ra, rd, ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 7) == 0) begin
                clr_integ = 1'b1;
                @(negedge clk);
                clr_integ = 1'b0;
                for (int k = 0; k < NA; k++) m_acc[k] = 0;
                check_outputs("idle_clr");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
